// File: rtl/recon_sse16.sv
// recon_sse16: sum of squared errors between the source and reconstructed 16x16 luma block, one row per cycle.
// Optional build macro RECON_SSE_EARLY_TERM_EN adds the sse_limit port and stops as soon as the partial SSE exceeds it.
module recon_sse16 #(
  parameter int BLOCK_SIZE = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]  Ysrc,
  input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]  Yrec,
`ifdef RECON_SSE_EARLY_TERM_EN
  input  logic [31:0]                         sse_limit,
`endif
  output logic [31:0]                         sse,
  output logic                                early_out,
  output logic                                busy,
  output logic                                done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAST_ROW = 4'(BLOCK_SIZE - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_row;
  logic               r_s1_valid;
  logic [20:0]        r_row_sum;
  logic [31:0]        r_acc;
  logic               r_early;
  logic               r_busy;
  logic               r_done;

  logic               w_active;
  logic               w_over;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_early_set;

  logic signed [8:0]  w_diff [BLOCK_SIZE];
  logic signed [17:0] w_prod [BLOCK_SIZE];
  logic [16:0]        w_sq   [BLOCK_SIZE];
  logic [20:0]        w_l1   [8];
  logic [20:0]        w_l2   [4];
  logic [20:0]        w_l3   [2];
  logic [20:0]        w_row_sum;

  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);

`ifdef RECON_SSE_EARLY_TERM_EN
  assign w_over = w_active && (r_acc > sse_limit);
`else
  assign w_over = 1'b0;
`endif

  // Stage 1 datapath: per-pixel signed difference, square, then a balanced adder tree.
  always_comb begin
    for (int c = 0; c < BLOCK_SIZE; c++) begin
      w_diff[c] = $signed({1'b0, Ysrc[8*(BLOCK_SIZE*int'(r_row) + c) +: 8]})
                - $signed({1'b0, Yrec[8*(BLOCK_SIZE*int'(r_row) + c) +: 8]});
      w_prod[c] = 18'(w_diff[c]) * 18'(w_diff[c]);
      w_sq[c]   = w_prod[c][16:0];
    end
    for (int i = 0; i < 8; i++) begin
      w_l1[i] = 21'(w_sq[2*i]) + 21'(w_sq[2*i+1]);
    end
    for (int i = 0; i < 4; i++) begin
      w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
    end
    for (int i = 0; i < 2; i++) begin
      w_l3[i] = w_l2[2*i] + w_l2[2*i+1];
    end
    w_row_sum = w_l3[0] + w_l3[1];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; DRAIN waits until stage 1 holds no pending row.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_RUN;
        else       w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (w_over)                 w_state_nxt = S_DONE;
        else if (r_row == LAST_ROW) w_state_nxt = S_DRAIN;
        else                        w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (w_over || !r_s1_valid) w_state_nxt = S_DONE;
        else                       w_state_nxt = S_DRAIN;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode, registered below so busy trails the state by one edge.
  always_comb begin
    w_busy_nxt  = w_active;
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_early_set = w_over;
  end

  // Status output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Row counter, stage 1 register and accumulator; a row caught behind an early stop is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row      <= 4'd0;
      r_s1_valid <= 1'b0;
      r_row_sum  <= 21'd0;
      r_acc      <= 32'd0;
      r_early    <= 1'b0;
    end else begin
      r_s1_valid <= (r_state == S_RUN) && !w_over;
      if (r_state == S_RUN) begin
        r_row_sum <= w_row_sum;
      end else begin
        r_row_sum <= r_row_sum;
      end
      if ((r_state == S_IDLE) && start) begin
        r_row   <= 4'd0;
        r_acc   <= 32'd0;
        r_early <= 1'b0;
      end else begin
        if (r_state == S_RUN) r_row <= r_row + 4'd1;
        else                  r_row <= r_row;
        if (w_active && r_s1_valid && !w_over) r_acc <= r_acc + {11'd0, r_row_sum};
        else                                   r_acc <= r_acc;
        if (w_early_set) r_early <= 1'b1;
        else             r_early <= r_early;
      end
    end
  end

  assign sse       = r_acc;
  assign early_out = r_early;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: doc/recon_sse16.md
# recon_sse16

Distortion stage downstream of the 16x16 luma reconstruction block. Takes the source macroblock and the reconstructed macroblock (`Yout`) and computes the sum of squared errors (SSE) for the intra-16 mode decision. It processes one raster row per cycle through a 2-stage pipeline and signals completion with a `done` pulse.

## Interface
- `BLOCK_SIZE`, default 16, sets the pixel edge length. Only 16 is supported.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle request pulse. Sampled only in IDLE.
- `Ysrc`  input  2048  source pixels, raster order. Pixel (r,c) occupies bits [8*(16r+c)+7 : 8*(16r+c)], unsigned.
- `Yrec`  input  2048  reconstructed pixels, same layout as `Ysrc` (the reconstruction stage's `Yout`).
- `sse_limit`  input  32  early-termination threshold. Present only with `RECON_SSE_EARLY_TERM_EN`.
- `sse`  output  32  result. Reset value 0.
- `early_out`  output  1  result was truncated by the limit. Reset value 0.
- `busy`  output  1  operation in progress. Reset value 0.
- `done`  output  1  one-cycle completion pulse. Reset value 0.

## Operation
- FSM states:
  - IDLE: on `start`, go to RUN.
  - RUN: row counter runs 0..15. After row 15 is issued, go to DRAIN.
  - DRAIN: wait for the last pipeline stage to empty, then go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- On entry to RUN, the accumulator and `early_out` are cleared to 0.
- `Ysrc` and `Yrec` are not latched. The upstream stage holds both stable from the `start` cycle through the `done` cycle.
- Stage 1, one registered edge:
  - Select row r from both inputs.
  - Form 16 signed 9-bit differences and square each (17-bit, max 65025).
  - Sum through an adder tree into a 21-bit row sum (max 1,040,400).
- Stage 2: the accumulator adds the row sum.
  - Accumulator is 32-bit. The true maximum is 16,646,400 (fits in 24 bits), so no saturation logic is needed.
- `sse` is driven from the accumulator register. It holds its value after `done` until the next accepted `start`.
- `start` while `busy` is ignored: no restart, no queuing.
- `rst` asserted mid-operation: immediate return to IDLE, all outputs go to 0, and no `done` is produced.

## Timing
- Edge E0 samples `start`.
- Row r sum is registered at E0+1+r.
- Row r is accumulated at E0+2+r. The last accumulation is at E0+17.
- `done` is high during the cycle after edge E0+18, i.e. latency 18 cycles. `sse` is valid in that same cycle.
- `busy` is high from E0+1 through the `done` cycle inclusive.
- Back-to-back operation: a `start` in the cycle after `done` is accepted. Throughput is 1 block per 19 cycles.

## Configuration
- `RECON_SSE_EARLY_TERM_EN` defined:
  - The `sse_limit` port exists.
  - At each accumulate edge E0+2+r, if the updated accumulator is strictly greater than `sse_limit`, the FSM goes straight to DONE.
  - The row already in stage 1 is discarded and no further rows are issued.
  - `done` is asserted at E0+3+r with `early_out`=1, and `sse` holds the partial sum.
  - If the limit is never exceeded, behaviour is identical to the undefined case with `early_out`=0.
- Undefined:
  - No `sse_limit` port.
  - All 16 rows are always processed.
  - `early_out` is tied to 0.

## Test plan
- Identical case: `Ysrc`=`Yrec`=random -> `done` 18 cycles after `start`; `sse`=0; `early_out`=0.
- Maximum case: `Ysrc` all 0xFF, `Yrec` all 0x00 -> `sse`=16,646,400 (0x00FE0100). Repeat with inputs swapped -> same value.
- Single pixel: one pixel (r=15, c=15) differs by -7, all others equal -> `sse`=49. Verifies the sign and the last row and column.
- `start` re-pulsed at E0+5 -> ignored; single `done` at E0+18 with the correct result. A `start` in the cycle after `done` -> second `done` 19 cycles later.
- `rst` pulsed at E0+10 -> `busy`, `done`, `sse` all 0 and no `done` afterwards. A new `start` then completes normally.
- Early termination (macro defined): every pixel differs by 1, `sse_limit`=40 -> `done` at E0+5, `sse`=48, `early_out`=1. Repeat with `sse_limit`=256 -> full run, `sse`=256, `early_out`=0.
